// File: rtl/ras_pkg.sv
// Shared definitions for the return-address-stack spill engine.
//   - ras_state_e   : engine FSM states
//   - RAS_CFG_*     : config register indices on the MMIO config write path
//   - RAS_CTRL_*    : bit positions inside the control register
//   - ras_slot_addr : byte address of a memory slot in the spill region
package ras_pkg;

  typedef enum logic {
    S_IDLE,
    S_FILL_WAIT
  } ras_state_e;

  localparam logic [2:0] RAS_CFG_BASE  = 3'd0;
  localparam logic [2:0] RAS_CFG_LIMIT = 3'd1;
  localparam logic [2:0] RAS_CFG_CTRL  = 3'd2;

  localparam int unsigned RAS_CTRL_EN_BIT  = 0;
  localparam int unsigned RAS_CTRL_CLR_BIT = 1;

  // Word slot -> byte address, wrapping modulo 2^32.
  function automatic logic [31:0] ras_slot_addr(input logic [31:0] base,
                                                input logic [29:0] slot);
    return base + {slot, 2'b00};
  endfunction

endpackage

// File: rtl/ras_lifo_buf.sv
// On-chip circular buffer holding the youngest return addresses.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears pointers only)
//   push_i       : write din_i above the top and advance top
//   pop_i        : retire the top entry
//   replace_i    : overwrite the top entry in place with din_i
//   drop_i       : retire the bottom (oldest) entry
//   din_i        : write data
//   top_o, bot_o : youngest / oldest entry
//   count_o      : live entries, 0..DEPTH
// push_i together with drop_i on a full buffer overwrites the oldest entry,
// since the slot above the top is the bottom when full.
module ras_lifo_buf #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       replace_i,
  input  logic                       drop_i,
  input  logic [31:0]                din_i,
  output logic [31:0]                top_o,
  output logic [31:0]                bot_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] top_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] bot_idx;

  assign bot_idx = top_q - PW'(count_q) + PW'(1);
  assign top_o   = mem_q[top_q];
  assign bot_o   = mem_q[bot_idx];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (replace_i) mem_q[top_q] <= din_i;
    if (push_i)    mem_q[top_q + PW'(1)] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      if (push_i)     top_q <= top_q + PW'(1);
      else if (pop_i) top_q <= top_q - PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i) - CW'(drop_i);
    end
  end

endmodule

// File: rtl/ras_spill_engine.sv
// Return-address stack with spill to / fill from a memory region.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   push, push_addr, pop     : call/return requests from the core
//   stall                    : request not accepted this cycle (combinational)
//   pop_valid, pop_addr      : registered pop result, one-cycle pulse
//   cfg_wr/cfg_addr/cfg_din  : config writes (base, limit, control)
//   mem_rdy                  : memory port granted this cycle
//   mem_rd/mem_wr/mem_addr/mem_din, mem_dout : memory port
//   overflow, underflow      : sticky error flags
//   spill_cnt                : entries currently held in memory
module ras_spill_engine
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [31:0]      push_addr,
  input  logic             pop,
  output logic             stall,
  output logic             pop_valid,
  output logic [31:0]      pop_addr,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_addr,
  input  logic [31:0]      cfg_din,
  input  logic             mem_rdy,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  input  logic [31:0]      mem_dout,
  output logic             overflow,
  output logic             underflow,
  output logic [CNT_W-1:0] spill_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  ras_state_e       state_q;
  logic [31:0]      base_q;
  logic [CNT_W-1:0] limit_q;
  logic             en_q;
  logic [CNT_W-1:0] spill_cnt_q;
  logic             overflow_q, underflow_q, pop_valid_q;
  logic [31:0]      pop_addr_q;

  logic [CW-1:0]    buf_count;
  logic [31:0]      buf_top, buf_bot;

  logic idle, full, empty, spill_ok, need_fill, spill_go, fill_go;
  logic do_push, do_pop, do_repl, do_drop, ovf_set, unf_set, pop_acc, pop_zero;
  logic buf_push;
  logic [31:0] buf_din;

  assign idle      = (state_q == S_IDLE);
  assign full      = (buf_count == CW'(DEPTH));
  assign empty     = (buf_count == '0);
  assign spill_ok  = en_q && (spill_cnt_q < limit_q);
  assign need_fill = idle && pop && empty && (spill_cnt_q != '0);
  assign spill_go  = idle && full && spill_ok && mem_rdy;
  assign fill_go   = need_fill && mem_rdy;

  // Request arbitration. A spill can coincide with an accepted pop or
  // push+pop, so the bottom drop is OR-ed in after the request decision.
  always_comb begin
    stall    = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_repl  = 1'b0;
    do_drop  = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    pop_acc  = 1'b0;
    pop_zero = 1'b0;
    if (!idle) begin
      stall = push | pop;
    end else if (need_fill) begin
      stall = 1'b1;
    end else if (push && !pop && full && spill_ok) begin
      stall = 1'b1;
    end else if (pop && empty) begin
      pop_acc  = 1'b1;
      pop_zero = 1'b1;
      unf_set  = 1'b1;
      do_push  = push;
    end else if (pop && push) begin
      pop_acc = 1'b1;
      do_repl = 1'b1;
    end else if (pop) begin
      pop_acc = 1'b1;
      do_pop  = 1'b1;
    end else if (push) begin
      do_push = 1'b1;
      if (full) begin
        do_drop = 1'b1;
        ovf_set = 1'b1;
      end
    end
    if (spill_go) do_drop = 1'b1;
  end

  // The filled word enters through the normal push path (count is 0).
  assign buf_push = do_push | (state_q == S_FILL_WAIT);
  assign buf_din  = (state_q == S_FILL_WAIT) ? mem_dout : push_addr;

  ras_lifo_buf #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push_i    (buf_push),
    .pop_i     (do_pop),
    .replace_i (do_repl),
    .drop_i    (do_drop),
    .din_i     (buf_din),
    .top_o     (buf_top),
    .bot_o     (buf_bot),
    .count_o   (buf_count)
  );

  always_comb begin
    mem_wr   = spill_go;
    mem_rd   = fill_go;
    mem_addr = '0;
    mem_din  = '0;
    if (spill_go) begin
      mem_addr = ras_slot_addr(base_q, 30'(spill_cnt_q));
      mem_din  = buf_bot;
    end else if (fill_go) begin
      mem_addr = ras_slot_addr(base_q, 30'(spill_cnt_q) - 30'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      limit_q     <= '0;
      en_q        <= 1'b0;
      spill_cnt_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      pop_valid_q <= 1'b0;
      pop_addr_q  <= '0;
    end else begin
      pop_valid_q <= pop_acc;
      if (pop_acc) pop_addr_q <= pop_zero ? '0 : buf_top;

      case (state_q)
        S_IDLE: begin
          if (spill_go) spill_cnt_q <= spill_cnt_q + CNT_W'(1);
          if (fill_go) begin
            spill_cnt_q <= spill_cnt_q - CNT_W'(1);
            state_q     <= S_FILL_WAIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (ovf_set) overflow_q  <= 1'b1;
      if (unf_set) underflow_q <= 1'b1;

      // Base/limit are frozen while memory holds entries; clear beats set.
      if (cfg_wr) begin
        case (cfg_addr)
          RAS_CFG_BASE:  if (spill_cnt_q == '0) base_q <= {cfg_din[31:2], 2'b00};
          RAS_CFG_LIMIT: if (spill_cnt_q == '0) limit_q <= cfg_din[CNT_W-1:0];
          RAS_CFG_CTRL: begin
            en_q <= cfg_din[RAS_CTRL_EN_BIT];
            if (cfg_din[RAS_CTRL_CLR_BIT]) begin
              overflow_q  <= 1'b0;
              underflow_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign pop_valid = pop_valid_q;
  assign pop_addr  = pop_addr_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign spill_cnt = spill_cnt_q;

endmodule
